// File: rtl/id_issue_ctrl_pkg.sv
// Shared constants and types for the decode/issue stage.
// This package stands in for define.h: the first block holds the existing machine constants, the second block holds the new ones.
package id_issue_ctrl_pkg;

  // Existing machine-wide constants.
  localparam int COMMON_WIDTH   = 32;
  localparam int REG_NUM        = 5;
  localparam int ALU_TYPE_WIDTH = 4;
  localparam logic [ALU_TYPE_WIDTH-1:0] ALU_NOP = 4'd0;

  // New constants for the issue controller.
  localparam int STALL_CNT_WIDTH = 16;
  localparam int NUM_ARCH_REGS   = 1 << REG_NUM;

  // Issue slot occupancy states.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/id_scoreboard.sv
// Register busy scoreboard.
// It has three lookup ports, and a writeback on an index releases that index in the same cycle.
// On a given bit, a set has priority over a clear.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [REG_NUM-1:0] set_idx,
  input  logic               clr_en,
  input  logic [REG_NUM-1:0] clr_idx,
  input  logic               flush_clr_en,
  input  logic [REG_NUM-1:0] flush_clr_idx,
  input  logic [REG_NUM-1:0] rs1_idx,
  input  logic [REG_NUM-1:0] rs2_idx,
  input  logic [REG_NUM-1:0] rd_idx,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               rd_busy
);

  logic [NUM_ARCH_REGS-1:0] busy_reg;
  logic [NUM_ARCH_REGS-1:0] busy_next;

  // A busy register whose writeback retires this cycle already counts as free.
  function automatic logic src_busy(input logic [NUM_ARCH_REGS-1:0] b,
                                    input logic [REG_NUM-1:0] idx,
                                    input logic wb_en,
                                    input logic [REG_NUM-1:0] wb_idx);
    return b[idx] && !(wb_en && (wb_idx == idx));
  endfunction

  // Lookup ports that apply same-cycle release.
  always_comb begin
    rs1_busy = src_busy(busy_reg, rs1_idx, clr_en, clr_idx);
    rs2_busy = src_busy(busy_reg, rs2_idx, clr_en, clr_idx);
    rd_busy  = src_busy(busy_reg, rd_idx,  clr_en, clr_idx);
  end

  // Next-state update: clears are applied first, then the set is applied, so the set wins.
  // x0 is never busy.
  always_comb begin
    busy_next = busy_reg;
    if (clr_en)       busy_next[clr_idx]       = 1'b0;
    if (flush_clr_en) busy_next[flush_clr_idx] = 1'b0;
    if (set_en)       busy_next[set_idx]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register. Reset drops every pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-to-execute issue controller.
// It uses a single holding slot to the EX stage, with scoreboard-based RAW and WAW hazard stalls, flush, and a saturating stall counter.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_TYPE_WIDTH-1:0]  in_alu_type,
  input  logic                       in_imm_tag,
  input  logic [COMMON_WIDTH-1:0]    in_imm,
  input  logic [REG_NUM-1:0]         in_rd,
  input  logic [REG_NUM-1:0]         in_rs1,
  input  logic [REG_NUM-1:0]         in_rs2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_TYPE_WIDTH-1:0]  out_alu_type,
  output logic                       out_imm_tag,
  output logic [COMMON_WIDTH-1:0]    out_imm,
  output logic [REG_NUM-1:0]         out_rd,
  output logic [REG_NUM-1:0]         out_rs1,
  output logic [REG_NUM-1:0]         out_rs2,
  input  logic                       wb_valid,
  input  logic [REG_NUM-1:0]         wb_rd,
  input  logic                       flush,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  issue_state_t state_reg;
  issue_state_t state_next;

  logic rs1_busy;
  logic rs2_busy;
  logic rd_busy;
  logic hazard;
  logic slot_free;
  logic transfer;
  logic stall_now;
  logic set_en;
  logic flush_clr_en;

  id_scoreboard u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en        (set_en),
    .set_idx       (in_rd),
    .clr_en        (wb_valid),
    .clr_idx       (wb_rd),
    .flush_clr_en  (flush_clr_en),
    .flush_clr_idx (out_rd),
    .rs1_idx       (in_rs1),
    .rs2_idx       (in_rs2),
    .rd_idx        (in_rd),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_busy       (rd_busy)
  );

  // Handshake and hazard evaluation. in_ready does not depend on in_valid.
  always_comb begin
    hazard       = rs1_busy || (!in_imm_tag && rs2_busy) || rd_busy;
    slot_free    = !out_valid || out_ready;
    in_ready     = slot_free && !hazard && !flush;
    transfer     = in_valid && in_ready;
    stall_now    = in_valid && hazard && slot_free && !flush;
    set_en       = transfer && (in_rd != '0) && (in_alu_type != ALU_NOP);
    flush_clr_en = flush && out_valid && (out_rd != '0) && (out_alu_type != ALU_NOP);
  end

  // Next-state logic for slot occupancy. out_valid is decoded from the state.
  always_comb begin
    state_next = ST_EMPTY;
    out_valid  = (state_reg == ST_FULL);
    if (flush)                       state_next = ST_EMPTY;
    else if (transfer)               state_next = ST_FULL;
    else if (stall_now)              state_next = ST_STALL;
    else if (out_valid && !out_ready) state_next = ST_FULL;
    else                             state_next = ST_EMPTY;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  // Holding slot fields. They load only on a transfer, so they stay stable while EX back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_alu_type <= ALU_NOP;
      out_imm_tag  <= 1'b0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
    end else if (transfer) begin
      out_alu_type <= in_alu_type;
      out_imm_tag  <= in_imm_tag;
      out_imm      <= in_imm;
      out_rd       <= in_rd;
      out_rs1      <= in_rs1;
      out_rs2      <= in_rs2;
    end
  end

  // Count every cycle in which a present instruction is held back only by a hazard. The count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_cnt <= '0;
    else if (stall_now && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl. Expected values are hand-computed.
module tb_id_issue_ctrl;
  import id_issue_ctrl_pkg::*;

  localparam logic [ALU_TYPE_WIDTH-1:0] ALU_ADD = 4'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_type;
  logic        in_imm_tag;
  logic [31:0] in_imm;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_type;
  logic        out_imm_tag;
  logic [31:0] out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_type(in_alu_type), .in_imm_tag(in_imm_tag), .in_imm(in_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_type(out_alu_type), .out_imm_tag(out_imm_tag), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] alu, input logic it,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    in_valid = v; in_alu_type = alu; in_imm_tag = it; in_imm = imm;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    #1;
  endtask

  function automatic logic [31:0] busy_now();
    return dut.u_sb.busy_reg;
  endfunction

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    drive(1'b0, ALU_NOP, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_busy", busy_now(), 32'd0);
    chk("rst_alu_type", {28'd0, out_alu_type}, {28'd0, ALU_NOP});
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // addi x1,x0,5
    out_ready = 1'b1;
    drive(1'b1, ALU_ADD, 1'b1, 32'd5, 5'd1, 5'd0, 5'd0);
    chk("addi_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("addi_out_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_out_rd", {27'd0, out_rd}, 32'd1);
    chk("addi_out_imm", out_imm, 32'd5);
    chk("addi_busy", busy_now(), 32'h0000_0002);

    // add x2,x1,x1 stalls on x1
    drive(1'b1, ALU_ADD, 1'b0, 32'd0, 5'd2, 5'd1, 5'd1);
    chk("raw_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_stall1", {16'd0, stall_cnt}, 32'd1);
    chk("raw_out_valid", {31'd0, out_valid}, 32'd0);
    #1;
    chk("raw_in_ready2", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_stall2", {16'd0, stall_cnt}, 32'd2);
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    chk("wb_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("raw_issue_rd", {27'd0, out_rd}, 32'd2);
    chk("raw_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_stall_hold", {16'd0, stall_cnt}, 32'd2);
    chk("raw_busy", busy_now(), 32'h0000_0004);

    // back-pressure: held add x2 must stay stable
    out_ready = 1'b0;
    drive(1'b1, ALU_ADD, 1'b1, 32'd9, 5'd6, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp_hold_%0d", i), {out_valid, 16'd0, out_alu_type, out_rd, out_rs1, out_imm_tag},
          {1'b1, 16'd0, ALU_ADD, 5'd2, 5'd1, 1'b0});
    end
    chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // set beats same-cycle clear on x3
    out_ready = 1'b1;
    drive(1'b1, ALU_ADD, 1'b1, 32'd3, 5'd3, 5'd0, 5'd0);
    tick();
    chk("x3_busy", busy_now(), 32'h0000_000C);
    wb_valid = 1'b1; wb_rd = 5'd3;
    drive(1'b1, ALU_ADD, 1'b1, 32'd7, 5'd3, 5'd0, 5'd0);
    chk("x3_waw_release", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("x3_set_wins", busy_now(), 32'h0000_000C);
    chk("x3_out_imm", out_imm, 32'd7);

    // flush held rd=4
    drive(1'b1, ALU_ADD, 1'b1, 32'd4, 5'd4, 5'd0, 5'd0);
    tick();
    chk("x4_busy", busy_now(), 32'h0000_001C);
    out_ready = 1'b0; flush = 1'b1;
    drive(1'b1, ALU_ADD, 1'b1, 32'd8, 5'd9, 5'd0, 5'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", busy_now(), 32'h0000_000C);

    // rd=0 and NOP never set busy
    out_ready = 1'b1;
    drive(1'b1, ALU_ADD, 1'b1, 32'd1, 5'd0, 5'd0, 5'd0);
    tick();
    chk("x0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("x0_busy", busy_now(), 32'h0000_000C);
    drive(1'b1, ALU_NOP, 1'b1, 32'd0, 5'd7, 5'd0, 5'd0);
    tick();
    chk("nop_out_rd", {27'd0, out_rd}, 32'd7);
    chk("nop_busy", busy_now(), 32'h0000_000C);

    // reset in the middle of a stall on x5
    drive(1'b1, ALU_ADD, 1'b1, 32'd5, 5'd5, 5'd0, 5'd0);
    tick();
    chk("x5_busy", busy_now(), 32'h0000_002C);
    drive(1'b1, ALU_ADD, 1'b0, 32'd0, 5'd8, 5'd5, 5'd0);
    chk("x5_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("x5_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", busy_now(), 32'd0);
    chk("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mid_rst_fields", {out_imm[15:0], out_alu_type, out_rd, out_rs1, out_rs2[1:0]}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, ALU_NOP, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/id_issue_ctrl.md
ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1  decoded instruction present.
REQ-004 SHALL have: in_ready  out  1  instruction accepted this cycle.
REQ-005 SHALL have: in_alu_type  in  ALU_TYPE_WIDTH  decoded ALU op.
REQ-006 SHALL have: in_imm_tag  in  1  1 = rs2 unused, immediate operand.
REQ-007 SHALL have: in_imm  in  COMMON_WIDTH (32)  sign-extended immediate.
REQ-008 SHALL have: in_rd, in_rs1, in_rs2  in  REG_NUM (5)  register indices.
REQ-009 SHALL have: out_valid  out  1  issued instruction held for EX.
REQ-010 SHALL have: out_ready  in  1  EX consumes held instruction.
REQ-011 SHALL have: out_alu_type, out_imm_tag, out_imm, out_rd, out_rs1, out_rs2  out  widths as inputs  held instruction fields.
REQ-012 SHALL have: wb_valid  in  1  writeback retiring this cycle.
REQ-013 SHALL have: wb_rd  in  5  register being written back.
REQ-014 SHALL have: flush  in  1  discard held instruction.
REQ-015 SHALL have: stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-016 SHALL keep a 32-bit busy scoreboard; busy[0] SHALL read 0 permanently.
REQ-017 SHALL treat a source busy when busy[rs] = 1 and not (wb_valid and wb_rd = rs) in the same cycle (writeback releases same-cycle).
REQ-018 SHALL evaluate hazard = busy(rs1) or (!in_imm_tag and busy(rs2)) or busy(rd) (WAW), with the same-cycle release rule.
REQ-019 SHALL compute slot_free = !out_valid or out_ready.
REQ-020 SHALL assert in_ready = slot_free and !hazard and !flush (combinational); a transfer occurs when in_valid and in_ready.
REQ-021 SHALL, on transfer, register all in_* fields into out_* and set out_valid next cycle (latency 1).
REQ-022 SHALL, on transfer with in_rd != 0 and in_alu_type != ALU_NOP, set busy[in_rd].
REQ-023 SHALL, on wb_valid with wb_rd != 0, clear busy[wb_rd]; if the same cycle sets that bit, set wins.
REQ-024 SHALL clear out_valid when out_ready and no transfer.
REQ-025 SHALL, on flush, clear out_valid and clear busy[out_rd] if out_valid, out_rd != 0 and out_alu_type != ALU_NOP; flush overrides out_ready and blocks transfer.
REQ-026 SHALL hold out_* stable while out_valid and !out_ready.
REQ-027 SHALL implement states EMPTY (out_valid=0), FULL (out_valid=1), STALL (in_valid and hazard and slot_free); EMPTY->FULL on transfer, FULL->EMPTY on consume/flush without transfer, FULL->FULL on consume with transfer, any->STALL while hazard persists, STALL->FULL on transfer.
REQ-028 SHALL increment stall_cnt each cycle in STALL, saturating at 16'hFFFF.
REQ-029 SHALL keep in_ready = 0 when in_valid = 0 except as given by REQ-020 (no dependence on in_valid).

Reset
REQ-030 SHALL, on rst_n low, immediately clear out_valid, busy[31:0], stall_cnt, state to EMPTY, and all out_* fields to 0 (out_alu_type = ALU_NOP).
REQ-031 SHALL, on reset mid-operation, discard held instruction and all pending busy bits with no writeback required.

Structure
REQ-032 SHALL take COMMON_WIDTH, REG_NUM, ALU_TYPE_WIDTH, ALU_NOP from define.h; new constants (STALL_CNT_WIDTH = 16, state encodings) SHALL be added to define.h.
REQ-033 SHALL place the scoreboard in sub-module id_scoreboard (set/clear/flush-clear ports, two read ports plus rd port with same-cycle release).

Verification
REQ-034 SHALL cover: reset, then addi x1,x0,5 (in_valid=1, out_ready=1) -> out_valid next cycle, out_rd=1, busy[1]=1.
REQ-035 SHALL cover: add x2,x1,x1 while busy[1] -> in_ready=0, stall_cnt increments per cycle; wb_valid, wb_rd=1 -> in_ready=1 that same cycle, issue next cycle.
REQ-036 SHALL cover: out_ready=0 with out_valid=1 -> in_ready=0, out_* unchanged 5 cycles.
REQ-037 SHALL cover: issue rd=3 and wb_rd=3 same cycle (prior busy) -> busy[3]=1 after edge.
REQ-038 SHALL cover: flush with held rd=4 -> out_valid=0, busy[4]=0 next cycle; rd=0 ops never set busy.
REQ-039 SHALL cover: rst_n pulsed low mid-stall with busy[5]=1 -> all outputs and busy cleared immediately, stall_cnt=0.
